// File: rtl/dp_mem_responder_if.sv
// Datapath-to-cache bus plus the RAM-model side, bundled for dp_mem_responder.
// The slave modport is the responder; the master modport is the environment
// (datapath driving requests and the RAM model answering them).
interface dp_mem_responder_if;
    // Datapath side
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        ihit;
    logic [31:0] imemload;
    logic        dhit;
    logic [31:0] dmemload;
    // RAM side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    // Status
    logic        timeout;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        input  ramload, ramstate,
        output ihit, imemload, dhit, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore, timeout
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        output ramload, ramstate,
        input  ihit, imemload, dhit, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore, timeout
    );
endinterface

// File: rtl/dp_mem_responder.sv
// Cache stand-in: arbitrates instruction fetches and data accesses onto a
// single-port RAM model and returns one-cycle ihit/dhit pulses. Data has
// strict priority, every completion is followed by a one-cycle bubble, and a
// sticky watchdog flags accesses that wait too long for ACCESS.
module dp_mem_responder #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic               CLK,
    input  logic               nRST,
    dp_mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IREQ = 2'd1,
        ST_DREQ = 2'd2
    } state_t;

    localparam logic [1:0]       RAM_ACCESS = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TO     = CNT_W'(TIMEOUT_CYCLES);

    state_t             r_state;
    logic               r_kind;      // 1 = write, 0 = read (data access only)
    logic               r_ihit;
    logic               r_dhit;
    logic [31:0]        r_imemload;
    logic [31:0]        r_dmemload;
    logic               r_ramren;
    logic               r_ramwen;
    logic [31:0]        r_ramaddr;
    logic [31:0]        r_ramstore;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_timeout;

    logic               w_access;
    logic               w_dreq;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Decode RAM handshake, pending data request and saturating counter increment.
    always_comb begin
        w_access  = (bus.ramstate == RAM_ACCESS);
        w_dreq    = bus.dmemREN | bus.dmemWEN;
        w_cnt_inc = r_cnt;
        if (r_cnt != CNT_MAX) begin
            w_cnt_inc = r_cnt + CNT_ONE;
        end else begin
            w_cnt_inc = CNT_MAX;
        end
    end

    // Arbitration FSM with registered RAM controls, hit pulses and watchdog.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= ST_IDLE;
            r_kind     <= 1'b0;
            r_ihit     <= 1'b0;
            r_dhit     <= 1'b0;
            r_imemload <= 32'h0000_0000;
            r_dmemload <= 32'h0000_0000;
            r_ramren   <= 1'b0;
            r_ramwen   <= 1'b0;
            r_ramaddr  <= 32'h0000_0000;
            r_ramstore <= 32'h0000_0000;
            r_cnt      <= {CNT_W{1'b0}};
            r_timeout  <= 1'b0;
        end else begin
            // Hits are single-cycle pulses unless set again below.
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (r_ihit | r_dhit) begin
                        // Bubble cycle: let the datapath move on before the next grant.
                        r_ramren <= 1'b0;
                        r_ramwen <= 1'b0;
                    end else if (w_dreq) begin
                        r_state    <= ST_DREQ;
                        r_ramaddr  <= bus.dmemaddr;
                        r_ramstore <= bus.dmemstore;
                        r_kind     <= bus.dmemWEN;
                        r_ramwen   <= bus.dmemWEN;
                        r_ramren   <= ~bus.dmemWEN;
                    end else if (bus.imemREN & ~bus.halt) begin
                        r_state   <= ST_IREQ;
                        r_ramaddr <= bus.imemaddr;
                        r_ramren  <= 1'b1;
                        r_ramwen  <= 1'b0;
                    end else begin
                        r_ramren <= 1'b0;
                        r_ramwen <= 1'b0;
                    end
                end
                ST_IREQ: begin
                    if (!bus.imemREN) begin
                        // Requester withdrew: abandon, any ACCESS this edge is ignored.
                        r_state  <= ST_IDLE;
                        r_ramren <= 1'b0;
                        r_ramwen <= 1'b0;
                        r_cnt    <= {CNT_W{1'b0}};
                    end else if (w_access) begin
                        r_imemload <= bus.ramload;
                        r_ihit     <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_ramren   <= 1'b0;
                        r_ramwen   <= 1'b0;
                        r_cnt      <= {CNT_W{1'b0}};
                    end else begin
                        // FREE/BUSY/ERROR: keep asking, count the wait.
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNT_TO) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                ST_DREQ: begin
                    if (!w_dreq) begin
                        r_state  <= ST_IDLE;
                        r_ramren <= 1'b0;
                        r_ramwen <= 1'b0;
                        r_cnt    <= {CNT_W{1'b0}};
                    end else if (w_access) begin
                        if (!r_kind) begin
                            r_dmemload <= bus.ramload;
                        end
                        r_dhit   <= 1'b1;
                        r_state  <= ST_IDLE;
                        r_ramren <= 1'b0;
                        r_ramwen <= 1'b0;
                        r_cnt    <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNT_TO) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_ramren <= 1'b0;
                    r_ramwen <= 1'b0;
                    r_cnt    <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.ihit     = r_ihit;
    assign bus.imemload = r_imemload;
    assign bus.dhit     = r_dhit;
    assign bus.dmemload = r_dmemload;
    assign bus.ramREN   = r_ramren;
    assign bus.ramWEN   = r_ramwen;
    assign bus.ramaddr  = r_ramaddr;
    assign bus.ramstore = r_ramstore;
    assign bus.timeout  = r_timeout;

endmodule
